ex_hazard_unit: RTL and testbench
=================================

// Module: ex_hazard_unit
// PURPOSE
//  Consumer-side control for the ID/EX pipeline register. Reads the ID-stage instruction and the EX-stage fields.
//  Tracks in-flight destination registers through MEM and WB in an internal scoreboard.
//  Produces EX-stage forwarding selects, the load-use stall and the ID/EX bubble (Flush_Ex).
//  Also produces the branch flush for IF/ID. Sits beside the ID/EX register in the pipelined core top.
// PARAMETERS
//  LOAD_USE_CYCLES  1   stall cycles per load-use hazard (1..7; >1 for slow data memory)
//  REG_ADDR_W       5   register-file address width
// PORTS
//  clk             in   1   core clock, all state on posedge
//  reset           in   1   asynchronous, active-low reset
//  Instr_ID        in   32  instruction in ID; rs=[25:21], rt=[20:16]
//  Branch_taken_ID in   1   branch/jump resolved taken in ID this cycle
//  Instr_Ex        in   32  instruction in EX; rd=[15:11]
//  RegWrite_Ex     in   1   EX instruction writes the register file
//  MemtoReg_Ex     in   1   EX instruction is a load
//  RegDst_Ex       in   1   1: dest=rd, 0: dest=rt
//  ForwardA_Ex     out  2   ALU src A: 00 regfile, 10 MEM result, 01 WB result
//  ForwardB_Ex     out  2   ALU src B (rt path), same encoding
//  Stall_IF        out  1   hold PC
//  Stall_ID        out  1   hold IF/ID register
//  Flush_Ex        out  1   load zeros (bubble) into ID/EX next edge
//  Flush_ID        out  1   clear IF/ID next edge
// BEHAVIOUR
//  - Reset (low, async): mem_dst=0, wb_dst=0, state=RUN, cnt=0; all outputs 0.
//  - ex_dst = RegWrite_Ex ? (RegDst_Ex ? Instr_Ex[15:11] : Instr_Ex[20:16]) : 0.
//  - Scoreboard, every posedge: mem_dst<=ex_dst; wb_dst<=mem_dst. Register 0 means "no write".
//  - Forwarding (combinational from Instr_Ex and scoreboard): per operand src in {rs,rt}:
//    - src!=0 && src==mem_dst -> 10.
//    - else src!=0 && src==wb_dst -> 01.
//    - else 00.
//    - MEM has priority over WB.
//  - Load-use detect: hz = MemtoReg_Ex && ex_dst!=0 && (ex_dst==Instr_ID rs || ex_dst==Instr_ID rt).
//  - FSM RUN/STALL:
//    - RUN: hz -> Stall_IF=Stall_ID=Flush_Ex=1 this cycle.
//      - LOAD_USE_CYCLES==1: stay RUN.
//      - else go STALL with cnt=LOAD_USE_CYCLES-1.
//    - STALL: Stall_IF=Stall_ID=Flush_Ex=1; cnt decrements; cnt==1 -> RUN on the next edge.
//    - Back-to-back hazards re-trigger from RUN normally.
//  - Branch: Flush_ID = Branch_taken_ID && !Stall_ID.
//    - Stall wins; the held branch re-resolves after the stall.
//  - Forwarding stays valid during stall cycles, since the bubble yields ex_dst=0.
//  - Reset mid-STALL aborts the stall immediately. No output is X after reset.
// CONFIGURATION
//  HAZ_STATS_EN defined:
//    - Adds outputs stall_count[31:0] and flush_count[31:0], cleared by reset.
//    - stall_count +1 per cycle with Stall_ID=1; flush_count +1 per Flush_ID pulse.
//    - Both saturate at 32'hFFFFFFFF.
//  HAZ_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Shared package: ALU forward-select encodings (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
//  - Shared package: FSM state type {RUN,STALL}; instruction field bit positions (RS_HI/LO, RT_HI/LO, RD_HI/LO).
//  - One natural sub-module: hazard_scoreboard (mem_dst/wb_dst shift register plus compare outputs).
//  - FSM, forward mux selects and flush logic live in the top module.
// TESTING
//  1 Reset: reset=0 mid-stream -> all outputs 0, scoreboard 0; release -> ForwardA/B_Ex=00.
//  2 EX-EX forward: add $3 (RegDst=1,RegWrite=1) then sub $5,$3,$4 in EX next cycle -> ForwardA_Ex=10, ForwardB_Ex=00.
//  3 MEM-priority: $3 written by two consecutive instrs, consumer rs=$3 -> ForwardA_Ex=10, not 01; rs=$0 -> 00.
//  4 Load-use: lw $2 in EX (MemtoReg=1), Instr_ID rt=$2 -> Stall_IF=Stall_ID=Flush_Ex=1 for exactly LOAD_USE_CYCLES (1 and 3 tested).
//    - Next cycle: ForwardB_Ex=01 (WB).
//  5 Branch vs stall: Branch_taken_ID=1 with load-use hz -> Flush_ID=0 during stall, 1 on the first RUN cycle.
//  6 HAZ_STATS_EN: 3-cycle stall then one branch flush -> stall_count=3, flush_count=1; reset mid-STALL -> counts 0, state RUN.

Source files
------------

// File: rtl/ex_hazard_unit_pkg.sv
// Shared definitions for the EX-stage hazard unit: forward-select codes,
// FSM state constants and instruction field positions.
package ex_hazard_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef logic [0:0] state_t;
  localparam state_t ST_RUN   = 1'b0;
  localparam state_t ST_STALL = 1'b1;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

endpackage

// File: rtl/ex_hazard_unit_scoreboard.sv
// Tracks the destination registers of the instructions in MEM and WB and
// reports which of them match the EX-stage source operands.
module hazard_scoreboard
  import ex_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  output logic                  rs_mem_hit,
  output logic                  rs_wb_hit,
  output logic                  rt_mem_hit,
  output logic                  rt_wb_hit
);

  logic [REG_ADDR_W-1:0] mem_dst;
  logic [REG_ADDR_W-1:0] wb_dst;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_dst <= '0;
      wb_dst  <= '0;
    end else begin
      mem_dst <= ex_dst;
      wb_dst  <= mem_dst;
    end
  end

  // Register 0 never carries a pending write, so it never matches.
  assign rs_mem_hit = (rs != '0) && (rs == mem_dst);
  assign rs_wb_hit  = (rs != '0) && (rs == wb_dst);
  assign rt_mem_hit = (rt != '0) && (rt == mem_dst);
  assign rt_wb_hit  = (rt != '0) && (rt == wb_dst);

endmodule

// File: rtl/ex_hazard_unit.sv
// EX-stage hazard unit: forwarding selects, load-use stall/bubble and branch
// flush. Optional counters are enabled with the HAZ_STATS_EN macro.
module ex_hazard_unit
  import ex_hazard_unit_pkg::*;
#(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int REG_ADDR_W      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_ID,
  input  logic        Branch_taken_ID,
  input  logic [31:0] Instr_Ex,
  input  logic        RegWrite_Ex,
  input  logic        MemtoReg_Ex,
  input  logic        RegDst_Ex,
  output logic [1:0]  ForwardA_Ex,
  output logic [1:0]  ForwardB_Ex,
  output logic        Stall_IF,
  output logic        Stall_ID,
  output logic        Flush_Ex,
  output logic        Flush_ID,
  output state_t      dbg_state
`ifdef HAZ_STATS_EN
  ,output logic [31:0] stall_count
  ,output logic [31:0] flush_count
`endif
);

  logic [REG_ADDR_W-1:0] ex_dst;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  hz;
  logic                  stall;
  logic                  rs_mem_hit, rs_wb_hit, rt_mem_hit, rt_wb_hit;
  state_t                state, state_nxt;
  logic [2:0]            cnt, cnt_nxt;
  logic                  unused_bits;

  assign unused_bits = ^{Instr_ID, Instr_Ex};

  assign ex_dst = !RegWrite_Ex ? '0 :
                  RegDst_Ex    ? Instr_Ex[RD_LO +: REG_ADDR_W] : Instr_Ex[RT_LO +: REG_ADDR_W];
  assign id_rs  = Instr_ID[RS_LO +: REG_ADDR_W];
  assign id_rt  = Instr_ID[RT_LO +: REG_ADDR_W];

  hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .ex_dst     (ex_dst),
    .rs         (Instr_Ex[RS_LO +: REG_ADDR_W]),
    .rt         (Instr_Ex[RT_LO +: REG_ADDR_W]),
    .rs_mem_hit (rs_mem_hit),
    .rs_wb_hit  (rs_wb_hit),
    .rt_mem_hit (rt_mem_hit),
    .rt_wb_hit  (rt_wb_hit)
  );

  // MEM holds the younger result, so it wins over WB.
  assign ForwardA_Ex = rs_mem_hit ? FWD_MEM : (rs_wb_hit ? FWD_WB : FWD_RF);
  assign ForwardB_Ex = rt_mem_hit ? FWD_MEM : (rt_wb_hit ? FWD_WB : FWD_RF);

  assign hz = MemtoReg_Ex && (ex_dst != '0) && ((ex_dst == id_rs) || (ex_dst == id_rt));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    case (state)
      ST_RUN: begin
        if (hz) begin
          stall = 1'b1;
          if (LOAD_USE_CYCLES > 1) begin
            state_nxt = ST_STALL;
            cnt_nxt   = 3'(LOAD_USE_CYCLES - 1);
          end
        end
      end
      default: begin
        stall   = 1'b1;
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign Stall_IF  = stall;
  assign Stall_ID  = stall;
  assign Flush_Ex  = stall;
  // A held branch re-resolves once the stall releases IF/ID.
  assign Flush_ID  = Branch_taken_ID && !stall;
  assign dbg_state = state;

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (Stall_ID && (stall_count != '1)) stall_count <= stall_count + 32'd1;
      if (Flush_ID && (flush_count != '1)) flush_count <= flush_count + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ex_hazard_unit.sv
// Bench for ex_hazard_unit: two instances (1- and 3-cycle load-use stall)
// driven by shared directed and random stimulus against a reference model.
module tb_ex_hazard_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_id = '0;
  logic        br = 1'b0;
  logic [31:0] instr_ex = '0;
  logic        reg_write = 1'b0;
  logic        mem_to_reg = 1'b0;
  logic        reg_dst = 1'b0;

  logic [1:0]  fa [2];
  logic [1:0]  fb [2];
  logic        sif [2];
  logic        sid [2];
  logic        fex [2];
  logic        fid [2];
  logic [0:0]  dbg [2];
`ifdef HAZ_STATS_EN
  logic [31:0] scnt [2];
  logic [31:0] fcnt [2];
`endif

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Reference model state
  logic [4:0]  dst_q[$] = '{5'd0, 5'd0};
  int          stall_left [2] = '{0, 0};
  int          ncyc [2] = '{1, 3};
  logic [31:0] exp_sc [2] = '{32'd0, 32'd0};
  logic [31:0] exp_fc [2] = '{32'd0, 32'd0};

  always #5 clk = ~clk;

  ex_hazard_unit #(.LOAD_USE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .Instr_ID(instr_id), .Branch_taken_ID(br),
    .Instr_Ex(instr_ex), .RegWrite_Ex(reg_write), .MemtoReg_Ex(mem_to_reg),
    .RegDst_Ex(reg_dst), .ForwardA_Ex(fa[0]), .ForwardB_Ex(fb[0]),
    .Stall_IF(sif[0]), .Stall_ID(sid[0]), .Flush_Ex(fex[0]), .Flush_ID(fid[0]),
    .dbg_state(dbg[0])
`ifdef HAZ_STATS_EN
    ,.stall_count(scnt[0]), .flush_count(fcnt[0])
`endif
  );

  ex_hazard_unit #(.LOAD_USE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .Instr_ID(instr_id), .Branch_taken_ID(br),
    .Instr_Ex(instr_ex), .RegWrite_Ex(reg_write), .MemtoReg_Ex(mem_to_reg),
    .RegDst_Ex(reg_dst), .ForwardA_Ex(fa[1]), .ForwardB_Ex(fb[1]),
    .Stall_IF(sif[1]), .Stall_ID(sid[1]), .Flush_Ex(fex[1]), .Flush_ID(fid[1]),
    .dbg_state(dbg[1])
`ifdef HAZ_STATS_EN
    ,.stall_count(scnt[1]), .flush_count(fcnt[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else pass_cnt++;
  endtask

  function automatic logic [31:0] mk(input int rs, input int rt, input int rd);
    logic [31:0] v;
    v = '0;
    v[25:21] = 5'(rs);
    v[20:16] = 5'(rt);
    v[15:11] = 5'(rd);
    return v;
  endfunction

  // Youngest pending write (MEM) is dst_q[0], older (WB) is dst_q[1].
  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (src != 0 && src == dst_q[0]) return 2'b10;
    if (src != 0 && src == dst_q[1]) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step(input logic [31:0] iid, input logic b, input logic [31:0] iex,
                      input logic rw, input logic m2r, input logic rd, input string tag);
    logic [4:0] ex_dst;
    logic       hz, stl, f;
    @(negedge clk);
    instr_id = iid; br = b; instr_ex = iex;
    reg_write = rw; mem_to_reg = m2r; reg_dst = rd;
    #1;
    ex_dst = rw ? (rd ? iex[15:11] : iex[20:16]) : 5'd0;
    hz = m2r && ex_dst != 0 && (ex_dst == iid[25:21] || ex_dst == iid[20:16]);
    for (int k = 0; k < 2; k++) begin
      stl = (stall_left[k] > 0) || hz;
      f = b && !stl;
      check($sformatf("%s.fwd%0d", tag, k), {30'd0, fa[k], fb[k]},
            {28'd0, exp_fwd(iex[25:21]), exp_fwd(iex[20:16])});
      check($sformatf("%s.ctl%0d", tag, k), {28'd0, sif[k], sid[k], fex[k], fid[k]},
            {28'd0, stl, stl, stl, f});
      check($sformatf("%s.st%0d", tag, k), {31'd0, dbg[k]}, {31'd0, stall_left[k] > 0});
`ifdef HAZ_STATS_EN
      check($sformatf("%s.sc%0d", tag, k), scnt[k], exp_sc[k]);
      check($sformatf("%s.fc%0d", tag, k), fcnt[k], exp_fc[k]);
`endif
      if (stl && exp_sc[k] != '1) exp_sc[k]++;
      if (f && exp_fc[k] != '1) exp_fc[k]++;
      if (stall_left[k] > 0) stall_left[k]--;
      else if (hz) stall_left[k] = ncyc[k] - 1;
    end
    dst_q.push_front(ex_dst);
    void'(dst_q.pop_back());
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    instr_id = '0; br = 1'b0; instr_ex = '0;
    reg_write = 1'b0; mem_to_reg = 1'b0; reg_dst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s.out%0d", tag, k),
            {24'd0, fa[k], fb[k], sif[k], sid[k], fex[k], fid[k]}, 32'd0);
      check($sformatf("%s.st%0d", tag, k), {31'd0, dbg[k]}, 32'd0);
`ifdef HAZ_STATS_EN
      check($sformatf("%s.cnt%0d", tag, k), scnt[k] | fcnt[k], 32'd0);
`endif
      stall_left[k] = 0;
      exp_sc[k] = '0;
      exp_fc[k] = '0;
    end
    dst_q = '{5'd0, 5'd0};
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] nop;
    nop = '0;
    do_reset("reset0");

    // EX-EX forward: add $3,$1,$2 then sub $5,$3,$4
    step(nop, 0, mk(1, 2, 3), 1, 0, 1, "add");
    step(nop, 0, mk(3, 4, 5), 1, 0, 1, "sub");

    // MEM priority over WB, then rs=$0
    step(nop, 0, mk(1, 2, 3), 1, 0, 1, "w3a");
    step(nop, 0, mk(2, 1, 3), 1, 0, 1, "w3b");
    step(nop, 0, mk(3, 0, 6), 1, 0, 1, "use3");
    step(nop, 0, mk(0, 0, 7), 1, 0, 1, "rs0");

    // Load-use: lw $2 in EX, consumer rt=$2 held in ID
    step(mk(5, 2, 8), 0, mk(1, 2, 0), 1, 1, 0, "lw");
    step(mk(5, 2, 8), 0, nop, 0, 0, 0, "bub1");
    step(mk(5, 2, 8), 0, nop, 0, 0, 0, "bub2");
    step(nop, 0, mk(5, 2, 8), 1, 0, 1, "cons");

    // Branch vs stall
    step(mk(2, 0, 0), 1, mk(1, 4, 0), 1, 1, 0, "brlw");
    for (int i = 0; i < 4; i++) step(mk(2, 0, 0), 1, nop, 0, 0, 0, "brst");
    step(nop, 0, nop, 0, 0, 0, "idle");

    // Reset in the middle of a 3-cycle stall
    step(mk(6, 0, 0), 0, mk(1, 6, 0), 1, 1, 0, "lw2");
    step(mk(6, 0, 0), 0, nop, 0, 0, 0, "mid");
    do_reset("reset1");
    step(nop, 0, nop, 0, 0, 0, "post");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) do_reset("rreset");
      else
        step(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)) ^ {$urandom} & 32'hFC00_07FF,
             1'($urandom_range(0, 1)),
             mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)) ^ {$urandom} & 32'hFC00_07FF,
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
